// File: rtl/uart_pkg.sv
// Shared UART constants: default buffer depth and the width helper used to size
// occupancy counters that must hold 0..Depth inclusive.
package uart_pkg;

  localparam int DefaultDepth = 16;

  function automatic int count_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock first-word fall-through FIFO; head entry is read straight out of
// storage so a pushed byte is visible the cycle after its push edge.
module sync_fifo
  import uart_pkg::*;
#(
  parameter int Width = 8,
  parameter int Depth = DefaultDepth
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          push_i,
  input  logic [Width-1:0]              wdata_i,
  input  logic                          pop_i,
  output logic [Width-1:0]              rdata_o,
  output logic [count_width(Depth)-1:0] count_o
);

  localparam int PtrW = $clog2(Depth);
  localparam int CntW = count_width(Depth);

  logic [Width-1:0] mem_q [Depth];
  logic [PtrW-1:0]  wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0]  count_q;
  logic             do_push, do_pop;

  // Guards keep the pointers consistent even if a caller misbehaves.
  assign do_push = push_i && (count_q != CntW'(Depth));
  assign do_pop  = pop_i && (count_q != '0);

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata_i;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  assign rdata_o = mem_q[rd_ptr_q];
  assign count_o = count_q;

endmodule

// File: rtl/uart_rx_buffer.sv
// Buffers bytes from a UART receiver: a three-state arm/release FSM drives go and
// pushes each received byte exactly once into a sync_fifo read by the consumer.
module uart_rx_buffer
  import uart_pkg::*;
#(
  parameter int Depth = DefaultDepth
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [7:0]                    rx_data,
  input  logic                          rx_dr,
  output logic                          go,
  output logic [7:0]                    rd_data,
  output logic                          rd_valid,
  input  logic                          rd_ready,
  output logic [count_width(Depth)-1:0] count,
  output logic                          full,
  output logic [1:0]                    dbg_state_o
);

  localparam int CntW = count_width(Depth);

  // Encoding is visible on dbg_state_o: 0 = listen, 1 = release, 2 = hold.
  typedef enum logic [1:0] {
    StListen  = 2'd0,
    StRelease = 2'd1,
    StHold    = 2'd2
  } state_e;

  state_e          state_q;
  logic            push, pop;
  logic [CntW-1:0] fifo_count;

  // Handshakes: receiver byte is taken when go & rx_dr at an edge, and the
  // receiver keeps rx_dr high until it sees go low; consumer pops on
  // rd_valid & rd_ready at an edge.
  assign push = (state_q == StListen) && rx_dr;
  assign pop  = rd_valid && rd_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StRelease;
    end else begin
      case (state_q)
        StListen:  if (rx_dr) state_q <= StRelease;
        StRelease: if (!rx_dr) state_q <= full ? StHold : StListen;
        StHold:    if (!full) state_q <= StListen;
        default:   state_q <= StRelease;
      endcase
    end
  end

  sync_fifo #(
    .Width(8),
    .Depth(Depth)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (push),
    .wdata_i (rx_data),
    .pop_i   (pop),
    .rdata_o (rd_data),
    .count_o (fifo_count)
  );

  assign go          = (state_q == StListen);
  assign count       = fifo_count;
  assign rd_valid    = (fifo_count != '0);
  assign full        = (fifo_count == CntW'(Depth));
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_uart_rx_buffer.sv
// Bench for uart_rx_buffer: a behavioural receiver, a randomised consumer and a
// byte-queue reference model checked on every pop.
module tb_uart_rx_buffer;

  localparam int Depth = 16;
  localparam int CntW  = $clog2(Depth) + 1;
  localparam logic [1:0] S_LISTEN  = 2'd0;
  localparam logic [1:0] S_RELEASE = 2'd1;
  localparam logic [1:0] S_HOLD    = 2'd2;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [7:0]      rx_data;
  logic            rx_dr;
  logic            go;
  logic [7:0]      rd_data;
  logic            rd_valid;
  logic            rd_ready;
  logic [CntW-1:0] count;
  logic            full;
  logic [1:0]      dbg_state;

  logic [7:0] exp_q[$];
  int n_checks = 0;
  int n_bad    = 0;
  int pops     = 0;
  int accepted = 0;
  logic rand_rdy  = 1'b0;
  logic rdy_force = 1'b0;

  uart_rx_buffer #(.Depth(Depth)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .rx_data     (rx_data),
    .rx_dr       (rx_dr),
    .go          (go),
    .rd_data     (rd_data),
    .rd_valid    (rd_valid),
    .rd_ready    (rd_ready),
    .count       (count),
    .full        (full),
    .dbg_state_o (dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got=0x%0h want=0x%0h at %0t", tag, got, want, $time);
    end
  endtask

  // consumer: rd_ready changes mid-cycle, either random or forced
  always @(posedge clk) begin
    #2;
    rd_ready = rand_rdy ? 1'($urandom_range(0, 1)) : rdy_force;
  end

  // scoreboard: a pop will happen at the next edge
  always @(negedge clk) begin
    if (rst_n && rd_valid && rd_ready) begin
      pops++;
      if (exp_q.size() == 0) check("pop_extra", 32'd1, 32'd0);
      else check("pop_data", {24'd0, rd_data}, {24'd0, exp_q.pop_front()});
    end
  end

  // receiver model; caller is positioned 1 time unit after a rising edge
  task automatic send_byte(input logic [7:0] b, input int hold);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 500; i++) begin
      if (go) begin ok = 1'b1; break; end
      @(posedge clk); #1;
    end
    if (!ok) begin
      check("go_wait", 32'd0, 32'd1);
      return;
    end
    rx_data = b;
    rx_dr   = 1'b1;
    exp_q.push_back(b);
    accepted++;
    ok = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(posedge clk); #1;
      if (!go) begin ok = 1'b1; break; end
    end
    if (!ok) check("go_fall", 32'd0, 32'd1);
    repeat (hold) begin @(posedge clk); #1; end
    rx_dr = 1'b0;
  endtask

  task automatic drain();
    rdy_force = 1'b1;
    for (int i = 0; i < 400; i++) begin
      if (count == '0) break;
      @(posedge clk); #1;
    end
    rdy_force = 1'b0;
    repeat (2) begin @(posedge clk); #1; end
    check("drain_cnt", 32'(count), 32'd0);
    check("drain_model", 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got=timeout want=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; rx_dr = 1'b0; rx_data = 8'h00; rd_ready = 1'b0;

    // reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_go", 32'(go), 32'd0);
    check("rst_count", 32'(count), 32'd0);
    check("rst_valid", 32'(rd_valid), 32'd0);
    check("rst_full", 32'(full), 32'd0);
    rst_n = 1'b1;
    @(posedge clk); @(posedge clk); #1;
    check("arm_go", 32'(go), 32'd1);
    check("arm_state", 32'(dbg_state), 32'(S_LISTEN));

    // single byte, rx_dr held for several cycles
    rx_data = 8'hA5; rx_dr = 1'b1;
    exp_q.push_back(8'hA5); accepted++;
    @(posedge clk); #1;
    check("a5_valid", 32'(rd_valid), 32'd1);
    check("a5_data", 32'(rd_data), 32'hA5);
    check("a5_go_low", 32'(go), 32'd0);
    repeat (3) begin @(posedge clk); #1; end
    check("a5_once", 32'(count), 32'd1);
    rx_dr = 1'b0;
    @(posedge clk); #1;
    check("a5_rearm", 32'(go), 32'd1);
    drain();

    // fill to capacity
    for (int i = 0; i < Depth; i++) send_byte(8'(i), int'($urandom_range(0, 2)));
    @(posedge clk); #1;
    check("fill_full", 32'(full), 32'd1);
    check("fill_count", 32'(count), 32'(exp_q.size()));
    check("fill_state", 32'(dbg_state), 32'(S_HOLD));
    check("fill_go", 32'(go), 32'd0);
    check("fill_head", 32'(rd_data), 32'h00);
    rdy_force = 1'b1;
    @(posedge clk); #1;
    rdy_force = 1'b0;
    check("pop1_count", 32'(count), 32'd15);
    check("pop1_go", 32'(go), 32'd0);
    @(posedge clk); #1;
    check("pop1_rearm", 32'(go), 32'd1);

    // push and pop on the same edge at count 15
    rx_data = 8'h55; rx_dr = 1'b1; rdy_force = 1'b1;
    exp_q.push_back(8'h55); accepted++;
    @(posedge clk); #1;
    rdy_force = 1'b0;
    check("pp_count", 32'(count), 32'd15);
    check("pp_full", 32'(full), 32'd0);
    rx_dr = 1'b0;
    drain();

    // streaming with a random consumer; pointers wrap more than twice
    rand_rdy = 1'b1;
    for (int i = 0; i < 40; i++) send_byte(8'h10 + 8'(i), int'($urandom_range(0, 3)));
    rand_rdy = 1'b0;
    drain();

    // reset during release with five bytes buffered
    for (int i = 0; i < 4; i++) send_byte(8'h60 + 8'(i), 1);
    @(posedge clk); #1;
    rx_data = 8'h64; rx_dr = 1'b1;
    exp_q.push_back(8'h64); accepted++;
    @(posedge clk); #1;
    check("mid_count", 32'(count), 32'(exp_q.size()));
    check("mid_state", 32'(dbg_state), 32'(S_RELEASE));
    rst_n = 1'b0;
    #1;
    check("mid_rst_go", 32'(go), 32'd0);
    check("mid_rst_count", 32'(count), 32'd0);
    check("mid_rst_valid", 32'(rd_valid), 32'd0);
    accepted -= exp_q.size();
    exp_q.delete();
    rx_dr = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
    send_byte(8'h3C, 1);
    @(posedge clk); #1;
    check("post_rst_data", 32'(rd_data), 32'h3C);
    check("post_rst_count", 32'(count), 32'd1);
    drain();

    check("pop_total", 32'(pops), 32'(accepted));
    $display("test done: total=%0d bad=%0d", n_checks, n_bad);
    $finish;
  end

endmodule
